// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: valid/ready request, LATENCY wait states, held response.
// Optional DMEM_ERR_EN flags misaligned or illegal accesses and suppresses their stores.
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_funct3,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [3:0] LAT = 4'(LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    state_t              stateQ, stateD;
    logic [3:0]          cntQ;
    logic                weQ;
    logic [IDX_W+1:0]    addrQ;
    logic [31:0]         wdataQ;
    logic [2:0]          funct3Q;
    logic [31:0]         rdataQ;
    logic                errQ;

    logic [31:0]         mem [DEPTH];

    logic [IDX_W-1:0]    wordIdx;
    logic [31:0]         memWord;
    logic [7:0]          byteVal;
    logic [15:0]         halfVal;
    logic [31:0]         loadData;
    logic [31:0]         wrData;
    logic [3:0]          byteEn;
    logic                accessErr;
    logic                accept;

    // Address bits above the storage range are deliberately ignored (wrap).
    logic unusedAddrBits;
    assign unusedAddrBits = ^req_addr[ADDR_W-1:IDX_W+2];

    assign accept    = (stateQ == IDLE) && req_valid;
    assign req_ready = (stateQ == IDLE);
    assign rsp_valid = (stateQ == RESP);
    assign rsp_rdata = rdataQ;
    assign rsp_err   = errQ;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stateQ <= IDLE;
        else      stateQ <= stateD;
    end

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            IDLE:    if (req_valid) stateD = (LATENCY == 0) ? ACCESS : WAIT;
            WAIT:    if (cntQ == 4'd0) stateD = ACCESS;
            ACCESS:  stateD = RESP;
            RESP:    if (rsp_ready) stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    // Lane selection and extension; illegal codes fall through to word access.
    always_comb begin
        wordIdx   = addrQ[IDX_W+1:2];
        memWord   = mem[wordIdx];
        byteVal   = memWord[8*addrQ[1:0] +: 8];
        halfVal   = addrQ[1] ? memWord[31:16] : memWord[15:0];
        loadData  = memWord;
        wrData    = wdataQ;
        byteEn    = 4'b1111;
        accessErr = 1'b0;
        case (funct3Q)
            3'b000: begin
                loadData = {{24{byteVal[7]}}, byteVal};
                wrData   = {4{wdataQ[7:0]}};
                byteEn   = 4'b0001 << addrQ[1:0];
            end
            3'b001: begin
                loadData = {{16{halfVal[15]}}, halfVal};
                wrData   = {2{wdataQ[15:0]}};
                byteEn   = addrQ[1] ? 4'b1100 : 4'b0011;
            end
            3'b100: begin
                loadData = {24'd0, byteVal};
                wrData   = {4{wdataQ[7:0]}};
                byteEn   = 4'b0001 << addrQ[1:0];
            end
            3'b101: begin
                loadData = {16'd0, halfVal};
                wrData   = {2{wdataQ[15:0]}};
                byteEn   = addrQ[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                loadData = memWord;
                wrData   = wdataQ;
                byteEn   = 4'b1111;
            end
        endcase
`ifdef DMEM_ERR_EN
        case (funct3Q)
            3'b001, 3'b101:         accessErr = addrQ[0];
            3'b010:                 accessErr = (addrQ[1:0] != 2'b00);
            3'b000, 3'b100:         accessErr = 1'b0;
            default:                accessErr = 1'b1;
        endcase
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cntQ    <= 4'd0;
            weQ     <= 1'b0;
            addrQ   <= '0;
            wdataQ  <= 32'd0;
            funct3Q <= 3'd0;
            rdataQ  <= 32'd0;
            errQ    <= 1'b0;
        end else begin
            if (accept) begin
                cntQ    <= LAT;
                weQ     <= req_we;
                addrQ   <= req_addr[IDX_W+1:0];
                wdataQ  <= req_wdata;
                funct3Q <= req_funct3;
            end else if (stateQ == WAIT && cntQ != 4'd0) begin
                cntQ <= cntQ - 4'd1;
            end
            if (stateQ == ACCESS) begin
                rdataQ <= (weQ || accessErr) ? 32'd0 : loadData;
                errQ   <= accessErr;
            end
        end
    end

    // Storage is not reset; a store commits only in ACCESS, so reset abandons it.
    always_ff @(posedge clk) begin
        if (stateQ == ACCESS && weQ && !accessErr) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) mem[wordIdx][8*i +: 8] <= wrData[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder (DEPTH 1024, LATENCY 2).
// Error-reporting cases are selected by DMEM_ERR_EN to match the design build.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010,
                           F_BU = 3'b100, F_HU = 3'b101, F_ILL = 3'b011;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(1024), .LATENCY(2), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One request: push the expected response, wait for it, pop and compare.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [2:0] f3, input logic [31:0] expData,
                                 input logic expErr, input int hold);
        rsp_t e;
        int   lat;
        bit   got;
        @(negedge clk);
        checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        rsp_ready  = (hold == 0);
        expQ.push_back({expData, expErr});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        got = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                got = 1'b1;
                lat = k;
                break;
            end
        end
        checkOutput("rsp_timeout", 32'(got), 32'd1);
        checkOutput("latency", 32'(lat), 32'd4);
        if (expQ.size() == 0) begin
            checkOutput("scoreboard_empty", 32'd0, 32'd1);
            e = '0;
        end else begin
            e = expQ.pop_front();
        end
        checkOutput("rsp_rdata", rsp_rdata, e.data);
        checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            checkOutput("hold_valid", 32'(rsp_valid), 32'd1);
            checkOutput("hold_rdata", rsp_rdata, e.data);
            checkOutput("hold_req_ready", 32'(req_ready), 32'd0);
        end
        if (hold > 0) begin
            @(negedge clk);
            rsp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        checkOutput("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        checkOutput("req_ready_back", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_funct3 = 3'd0;
        rsp_ready  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);

        applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, F_W,  32'h00000000, 1'b0, 0);
        applyStimulus(1'b0, 32'h10, 32'h0,       F_W,  32'hDEADBEEF, 1'b0, 0);
        applyStimulus(1'b0, 32'h13, 32'h0,       F_B,  32'hFFFFFFDE, 1'b0, 0);
        applyStimulus(1'b0, 32'h13, 32'h0,       F_BU, 32'h000000DE, 1'b0, 0);
        applyStimulus(1'b0, 32'h12, 32'h0,       F_H,  32'hFFFFDEAD, 1'b0, 0);
        applyStimulus(1'b0, 32'h10, 32'h0,       F_HU, 32'h0000BEEF, 1'b0, 0);

        applyStimulus(1'b1, 32'h11, 32'hAAAAAA55, F_B, 32'h00000000, 1'b0, 0);
        applyStimulus(1'b0, 32'h10, 32'h0,        F_W, 32'hDEAD55EF, 1'b0, 0);
        applyStimulus(1'b1, 32'h12, 32'hFFFF1234, F_H, 32'h00000000, 1'b0, 0);
        applyStimulus(1'b0, 32'h10, 32'h0,        F_W, 32'h123455EF, 1'b0, 0);
        applyStimulus(1'b0, 32'h11, 32'h0,        F_B, 32'h00000055, 1'b0, 0);
        applyStimulus(1'b0, 32'h10, 32'h0,        F_H, 32'h000055EF, 1'b0, 0);

        applyStimulus(1'b0, 32'h10, 32'h0, F_W, 32'h123455EF, 1'b0, 5);

        applyStimulus(1'b1, 32'h1000, 32'hCAFEF00D, F_W, 32'h00000000, 1'b0, 0);
        applyStimulus(1'b0, 32'h0,    32'h0,        F_W, 32'hCAFEF00D, 1'b0, 0);
        applyStimulus(1'b0, 32'hFFFF_F000, 32'h0,   F_W, 32'hCAFEF00D, 1'b0, 0);

`ifdef DMEM_ERR_EN
        applyStimulus(1'b0, 32'h11, 32'h0,        F_W,   32'h00000000, 1'b1, 0);
        applyStimulus(1'b1, 32'h13, 32'h00009999, F_H,   32'h00000000, 1'b1, 0);
        applyStimulus(1'b0, 32'h10, 32'h0,        F_W,   32'h123455EF, 1'b0, 0);
        applyStimulus(1'b0, 32'h10, 32'h0,        F_ILL, 32'h00000000, 1'b1, 0);
`else
        applyStimulus(1'b0, 32'h11, 32'h0,        F_W,   32'h123455EF, 1'b0, 0);
        applyStimulus(1'b0, 32'h10, 32'h0,        F_ILL, 32'h123455EF, 1'b0, 0);
        applyStimulus(1'b1, 32'h13, 32'h00009999, F_H,   32'h00000000, 1'b0, 0);
        applyStimulus(1'b0, 32'h10, 32'h0,        F_W,   32'h999955EF, 1'b0, 0);
`endif

        // Abandon a store in its wait phase and confirm the word survives.
        applyStimulus(1'b1, 32'h20, 32'h0BADF00D, F_W, 32'h00000000, 1'b0, 0);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 32'h20;
        req_wdata  = 32'h11111111;
        req_funct3 = F_W;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkOutput("midrst_busy", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("midrst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("midrst_rsp_rdata", rsp_rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        applyStimulus(1'b0, 32'h20, 32'h0, F_W, 32'h0BADF00D, 1'b0, 0);

        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
